// File: rtl/scheduler_bitlet_stream_pkg.sv
// Shared types and width helpers for the bitlet stream scheduler.
package scheduler_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Widest index a row picker can report; sized well above any practical VEC_LENGTH.
    localparam int PICK_SEL_MAX = 16;

    typedef struct packed {
        logic [PICK_SEL_MAX-1:0] sel;
        logic                    val;
    } pick_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return idx_width(n) + 1;
    endfunction

endpackage

// File: rtl/scheduler_bitlet_stream_picker.sv
// Per-row bitlet picker: lowest set bit index plus the row with that bit cleared.
// With SCHED_DUAL_PICK_EN the highest remaining bit is also picked and cleared.
module bitlet_row_picker
    import scheduler_pkg::*;
#(
    parameter int VEC_LENGTH = 32,
    parameter int SEL_WIDTH  = idx_width(VEC_LENGTH)
) (
    input  logic [VEC_LENGTH-1:0] row_i,
    output logic [SEL_WIDTH-1:0]  lo_sel_o,
    output logic                  lo_val_o,
`ifdef SCHED_DUAL_PICK_EN
    output logic [SEL_WIDTH-1:0]  hi_sel_o,
    output logic                  hi_val_o,
`endif
    output logic [VEC_LENGTH-1:0] cleared_o
);

    pick_t                 lo;
    logic [VEC_LENGTH-1:0] lo_mask;
    logic [VEC_LENGTH-1:0] rest;

    always_comb begin
        lo = '0;
        for (int i = VEC_LENGTH - 1; i >= 0; i--) begin
            if (row_i[i]) lo.sel = PICK_SEL_MAX'(i);
        end
        lo.val = |row_i;
    end

    // Two's-complement trick isolates the lowest set bit without a decoder.
    assign lo_mask  = row_i & (~row_i + VEC_LENGTH'(1));
    assign rest     = row_i & ~lo_mask;
    assign lo_sel_o = lo.sel[SEL_WIDTH-1:0];
    assign lo_val_o = lo.val;

`ifdef SCHED_DUAL_PICK_EN
    pick_t                 hi;
    logic [VEC_LENGTH-1:0] hi_mask;

    always_comb begin
        hi = '0;
        for (int i = 0; i < VEC_LENGTH; i++) begin
            if (rest[i]) hi.sel = PICK_SEL_MAX'(i);
        end
        hi.val = |rest;
    end

    assign hi_mask   = hi.val ? (VEC_LENGTH'(1) << hi.sel) : '0;
    assign cleared_o = rest & ~hi_mask;
    assign hi_sel_o  = hi.sel[SEL_WIDTH-1:0];
    assign hi_val_o  = hi.val;

    logic unused_sel;
    assign unused_sel = ^{lo.sel[PICK_SEL_MAX-1:SEL_WIDTH], hi.sel[PICK_SEL_MAX-1:SEL_WIDTH]};
`else
    assign cleared_o = rest;

    logic unused_sel;
    assign unused_sel = ^lo.sel[PICK_SEL_MAX-1:SEL_WIDTH];
`endif

endmodule

// File: rtl/scheduler_bitlet_stream.sv
// Double-buffered bitlet scheduler streaming per-row set-bit indices to the bit-serial PE.
// Define SCHED_DUAL_PICK_EN to also emit the highest remaining bit per row each beat.
module scheduler_bitlet_stream
    import scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 32,
    parameter int SEL_WIDTH  = idx_width(VEC_LENGTH),
    parameter int CNT_WIDTH  = cnt_width(VEC_LENGTH)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             w_valid_i,
    output logic                             w_ready_o,
    input  logic [DATA_WIDTH*VEC_LENGTH-1:0] weight_i,
    input  logic                             out_ready_i,
    output logic                             out_valid_o,
    output logic [DATA_WIDTH*SEL_WIDTH-1:0]  act_sel_o,
    output logic [DATA_WIDTH-1:0]            act_val_o,
`ifdef SCHED_DUAL_PICK_EN
    output logic [DATA_WIDTH*SEL_WIDTH-1:0]  act_sel_hi_o,
    output logic [DATA_WIDTH-1:0]            act_val_hi_o,
`endif
    output logic                             out_last_o,
    output logic                             busy_o,
    output logic [CNT_WIDTH-1:0]             beat_cnt_o
);

    logic [DATA_WIDTH-1:0][VEC_LENGTH-1:0] weight_rows, shadow_q, active_q, cleared;
    logic [DATA_WIDTH-1:0][SEL_WIDTH-1:0]  pick_sel, act_sel_q;
    logic [DATA_WIDTH-1:0]                 pick_val, act_val_q;
    state_e                                state_q;
    logic                                  shadow_full_q, shadow_full_d, w_ready_q;
    logic                                  out_valid_q, out_last_q;
    logic [CNT_WIDTH-1:0]                  beat_cnt_q, run_cnt_q, cnt_inc;
    logic                                  adv, issue, set_done, swap, load;

`ifdef SCHED_DUAL_PICK_EN
    logic [DATA_WIDTH-1:0][SEL_WIDTH-1:0]  pick_sel_hi, act_sel_hi_q;
    logic [DATA_WIDTH-1:0]                 pick_val_hi, act_val_hi_q;
`endif

    assign weight_rows = weight_i;

    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_row
        bitlet_row_picker #(
            .VEC_LENGTH (VEC_LENGTH),
            .SEL_WIDTH  (SEL_WIDTH)
        ) u_pick (
            .row_i     (active_q[g]),
            .lo_sel_o  (pick_sel[g]),
            .lo_val_o  (pick_val[g]),
`ifdef SCHED_DUAL_PICK_EN
            .hi_sel_o  (pick_sel_hi[g]),
            .hi_val_o  (pick_val_hi[g]),
`endif
            .cleared_o (cleared[g])
        );
    end

    assign adv      = !out_valid_q || out_ready_i;
    assign issue    = (state_q == RUN) && adv;
    assign set_done = ~|cleared;
    assign cnt_inc  = (&run_cnt_q) ? run_cnt_q : run_cnt_q + CNT_WIDTH'(1);
    assign load     = w_valid_i && w_ready_q;
    // A swap only happens with a full shadow, when w_ready is already low, so it never races a load.
    assign swap          = shadow_full_q && ((state_q == IDLE) || (issue && set_done));
    assign shadow_full_d = load || (shadow_full_q && !swap);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            active_q      <= '0;
            shadow_full_q <= 1'b0;
            w_ready_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            act_sel_q     <= '0;
            act_val_q     <= '0;
            beat_cnt_q    <= '0;
            run_cnt_q     <= '0;
`ifdef SCHED_DUAL_PICK_EN
            act_sel_hi_q  <= '0;
            act_val_hi_q  <= '0;
`endif
        end else begin
            if (load) shadow_q <= weight_rows;
            shadow_full_q <= shadow_full_d;
            w_ready_q     <= !shadow_full_d;
            case (state_q)
                IDLE: begin
                    if (adv) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                    if (shadow_full_q) begin
                        active_q <= shadow_q;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (adv) begin
                        act_sel_q   <= pick_sel;
                        act_val_q   <= pick_val;
`ifdef SCHED_DUAL_PICK_EN
                        act_sel_hi_q <= pick_sel_hi;
                        act_val_hi_q <= pick_val_hi;
`endif
                        out_valid_q <= 1'b1;
                        out_last_q  <= set_done;
                        active_q    <= cleared;
                        if (set_done) begin
                            beat_cnt_q <= cnt_inc;
                            run_cnt_q  <= '0;
                            if (shadow_full_q) active_q <= shadow_q;
                            else               state_q  <= IDLE;
                        end else begin
                            run_cnt_q <= cnt_inc;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign w_ready_o   = w_ready_q;
    assign out_valid_o = out_valid_q;
    assign act_sel_o   = act_sel_q;
    assign act_val_o   = act_val_q;
    assign out_last_o  = out_last_q;
    assign beat_cnt_o  = beat_cnt_q;
    assign busy_o      = (state_q == RUN) || shadow_full_q;
`ifdef SCHED_DUAL_PICK_EN
    assign act_sel_hi_o = act_sel_hi_q;
    assign act_val_hi_o = act_val_hi_q;
`endif

endmodule

// File: doc/scheduler_bitlet_stream.md
Name: scheduler_bitlet_stream

Overview:
- Parametrised successor to the fixed 8x32 bitlet scheduler.
- Holds a DATA_WIDTH x VEC_LENGTH sign-magnitude weight bit-plane set.
- Each beat, every bit-plane row emits the index of its lowest remaining set bit, then clears that bit, until the set is exhausted.
- Adds double-buffered weight loading with a valid/ready handshake, output backpressure, end-of-set marking and a beat counter; sits between the weight SRAM and the activation select muxes of the bit-serial PE.

Parameters:
- DATA_WIDTH, 8, number of bit-plane rows.
- VEC_LENGTH, 32, bits per row (any value >= 2, not restricted to a power of two).
- SEL_WIDTH, $clog2(VEC_LENGTH), act_sel index width.
- CNT_WIDTH, $clog2(VEC_LENGTH)+1, beat-counter width.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous active-high reset.
- w_valid, input, 1, weight set offered.
- w_ready, output, 1, shadow bank free.
- weight, input, DATA_WIDTH x VEC_LENGTH, weight bit-planes (row j = bit j).
- out_ready, input, 1, consumer accepts the current beat.
- out_valid, output, 1, beat present.
- act_sel, output, DATA_WIDTH x SEL_WIDTH, per-row selected activation index.
- act_val, output, DATA_WIDTH x 1, per-row index valid.
- out_last, output, 1, final beat of the current weight set.
- busy, output, 1, state is RUN or the shadow bank is full.
- beat_cnt, output, CNT_WIDTH, beat count of the last completed set.

Behaviour:
- Reset values: all outputs 0; both banks cleared; shadow_full = 0; FSM = IDLE. Reset mid-set discards both banks and drops out_valid the next cycle.
- Load:
  - w_ready = !shadow_full (registered, no combinational path from the FSM).
  - On w_valid && w_ready: shadow <= weight, shadow_full <= 1.
  - A slot freed by a swap becomes visible on w_ready the following cycle.
- Advance condition: adv = !out_valid || out_ready.
- FSM states:
  - IDLE:
    - If shadow_full: active <= shadow, shadow_full <= 0, go to RUN.
    - Otherwise remain in IDLE.
  - RUN, when adv is high:
    - Per row: act_sel = lowest set index (LSB-first); act_val = row non-zero.
    - Register act_sel/act_val and set out_valid = 1.
    - Clear the picked bit in the active bank.
    - out_last = 1 when the post-clear active bank is all zero.
  - On the last beat:
    - beat_cnt <= beats issued for this set, including this beat.
    - If shadow_full: swap shadow into active in the same cycle and stay in RUN (zero-bubble back-to-back sets).
    - Otherwise go to IDLE.
  - RUN when adv is low (stall): active bank, registered outputs and out_last all hold.
- Leaving RUN: if adv is high and the FSM is not issuing a beat, out_valid <= 0.
- All-zero weight set: exactly one beat with all act_val = 0 and out_last = 1; beat_cnt = 1.
- Beats per set = max over rows of popcount, minimum 1.
- Latency: weight accepted at edge t while IDLE with an empty active bank gives out_valid high after edge t+2.
- Simultaneous load and swap in the same cycle: the load is blocked because w_ready was 0; no data is lost.
- beat_cnt saturates at 2^CNT_WIDTH-1.

Optional Feature:
- Macro: SCHED_DUAL_PICK_EN.
- When defined:
  - Adds outputs act_sel_hi (DATA_WIDTH x SEL_WIDTH) and act_val_hi (DATA_WIDTH x 1).
  - Each beat a row also picks its highest remaining set bit and clears both picked bits.
  - act_val_hi = 0 when the row has at most one remaining bit.
  - Beats = max over rows of ceil(popcount/2), minimum 1.
- When undefined: the ports are absent and the single LSB-first pick applies.

Decomposition:
- Package scheduler_pkg holds:
  - the state enum (IDLE, RUN);
  - a function computing SEL_WIDTH/CNT_WIDTH defaults;
  - the pick-struct typedef {sel, val}.
- One sub-module, bitlet_row_picker (parametrised VEC_LENGTH): combinational lowest-set-bit encoder plus a cleared-row output (and a high pick under the macro). It replaces the fixed 32-to-5 encoder/decoder pair and is instantiated DATA_WIDTH times.

Test Plan:
- Load row0 = 32'h0000_0015, other rows 0, out_ready = 1. Required response:
  - Three beats, row0 act_sel = 0, 2, 4 with act_val = 1.
  - Other rows act_val = 0.
  - out_last on beat 3; beat_cnt = 3.
- Load an all-zero set. Required: one beat, all act_val = 0, out_last = 1, beat_cnt = 1.
- Load set A (row3 = 32'h8000_0001), then set B (row0 = 32'h2) while A runs. Required:
  - Beats: A (sel 0, then 31, last), then B (sel 1, last) on consecutive cycles, with no bubble.
  - w_ready low while the shadow bank is full.
- Hold out_ready = 0 for 4 cycles mid-set. Required: act_sel, act_val and out_last stable; no bits lost; total beat count unchanged.
- Assert reset during beat 2 of a 5-beat set. Required: next cycle out_valid = 0, w_ready = 1, beat_cnt = 0; a following load starts from a clean state.
- With SCHED_DUAL_PICK_EN, load row0 = 32'h0000_0107. Required:
  - Beat 1: lo 0, hi 8.
  - Beat 2: lo 1, hi 2, out_last = 1.
  - beat_cnt = 2.
